// File: rtl/ibexc_trace_pkg.sv
// Shared types for the RVFI retirement-trace buffer.
// IBEXC_TRACE_CAP_EN adds the destination capability (rd_wcap) to every trace record.
package ibexc_trace_pkg;

    localparam int unsigned ORDER_W = 16;

    // Reduced view of a CHERIoT register capability, enough to follow cap writes in a trace.
    typedef struct packed {
        logic        valid;
        logic [31:0] cursor;
        logic [31:0] meta;
    } reg_cap_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        POST   = 2'd2,
        FROZEN = 2'd3
    } trace_state_e;

    typedef enum logic {
        STREAM = 1'b0,
        RING   = 1'b1
    } trace_mode_e;

    typedef struct packed {
        logic [ORDER_W-1:0] order;
        logic [31:0]        pc;
        logic [31:0]        insn;
        logic [4:0]         rd_addr;
        logic [31:0]        rd_wdata;
        logic [31:0]        mem_addr;
        logic               trap;
`ifdef IBEXC_TRACE_CAP_EN
        reg_cap_t           rd_wcap;
`endif
    } trace_rec_t;

endpackage

// File: rtl/ibexc_rvfi_trace_buf_if.sv
// RVFI retirement input and trace-record drain port of the trace buffer.
// IBEXC_TRACE_CAP_EN adds rvfi_rd_wcap to the retirement side.
interface ibexc_rvfi_trace_buf_if
    import ibexc_trace_pkg::*;
();

    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic [31:0] rvfi_pc_rdata;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_mem_addr;
    logic [4:0]  rvfi_rd_addr;
    logic        rvfi_trap;
`ifdef IBEXC_TRACE_CAP_EN
    reg_cap_t    rvfi_rd_wcap;
`endif

    logic        rec_valid;
    logic        rec_ready;
    trace_rec_t  rec_data;

    // The master is the core/consumer side; the slave is the trace buffer itself.
    modport master (
        output rvfi_valid, rvfi_order, rvfi_insn, rvfi_pc_rdata,
        output rvfi_rd_wdata, rvfi_mem_addr, rvfi_rd_addr, rvfi_trap,
`ifdef IBEXC_TRACE_CAP_EN
        output rvfi_rd_wcap,
`endif
        output rec_ready,
        input  rec_valid, rec_data
    );

    modport slave (
        input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_pc_rdata,
        input  rvfi_rd_wdata, rvfi_mem_addr, rvfi_rd_addr, rvfi_trap,
`ifdef IBEXC_TRACE_CAP_EN
        input  rvfi_rd_wcap,
`endif
        input  rec_ready,
        output rec_valid, rec_data
    );

endinterface

// File: rtl/ibexc_trace_ring.sv
// Record storage for the trace buffer: flop array with wrap-bit pointers.
// Record width follows trace_rec_t, so it grows when IBEXC_TRACE_CAP_EN is defined.
module ibexc_trace_ring
    import ibexc_trace_pkg::*;
#(
    parameter  int unsigned Depth = 16,
    localparam int unsigned PtrW  = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            overwrite_i,
    input  trace_rec_t      wdata_i,
    output trace_rec_t      head_o,
    output logic            empty_o,
    output logic            full_o,
    output logic [PtrW-1:0] level_o
);

    localparam int unsigned IdxW = PtrW - 1;

    trace_rec_t      mem [Depth];
    logic [PtrW-1:0] head_q;
    logic [PtrW-1:0] tail_q;
    logic            write;

    // An overwrite writes the tail slot and retires the oldest record in the same edge.
    assign write = push_i | overwrite_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
        end else if (clear_i) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (write) begin
                tail_q <= tail_q + PtrW'(1);
            end
            if (pop_i || overwrite_i) begin
                head_q <= head_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (write) begin
            mem[tail_q[IdxW-1:0]] <= wdata_i;
        end
    end

    assign empty_o = (head_q == tail_q);
    assign full_o  = (head_q[PtrW-1] != tail_q[PtrW-1]) &&
                     (head_q[IdxW-1:0] == tail_q[IdxW-1:0]);
    assign level_o = tail_q - head_q;
    assign head_o  = empty_o ? '0 : mem[head_q[IdxW-1:0]];

endmodule

// File: rtl/ibexc_rvfi_trace_buf.sv
// RVFI retirement-trace buffer: capture FSM, trap trigger with post count, drop counter.
// Define IBEXC_TRACE_CAP_EN to record the destination capability of each retirement.
module ibexc_rvfi_trace_buf
    import ibexc_trace_pkg::*;
#(
    parameter  int unsigned Depth    = 16,
    parameter  int unsigned OrderW   = ORDER_W,
    parameter  int unsigned DropCntW = 16,
    localparam int unsigned LvlW     = $clog2(Depth) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic                  mode_i,
    input  logic                  trig_on_trap_i,
    input  logic [7:0]            post_cnt_i,
    ibexc_rvfi_trace_buf_if.slave trace,
    output logic [LvlW-1:0]       level_o,
    output logic [DropCntW-1:0]   drop_cnt_o,
    output trace_state_e          state_o
);

    trace_state_e          state_q;
    trace_mode_e           mode_q;
    logic [7:0]            post_q;
    logic [DropCntW-1:0]   drop_q;

    logic       capture;
    logic       pop;
    logic       push;
    logic       lose;
    logic       overwrite;
    logic       full;
    logic       empty;
    logic       unused_order_hi;
    trace_rec_t wrec;

    // A retirement seen in ARMED/POST counts as captured even if STREAM mode then drops it.
    assign capture   = trace.rvfi_valid && !clear_i && (state_q == ARMED || state_q == POST);
    assign pop       = trace.rec_ready && !empty && !clear_i;
    assign push      = capture && (!full || pop);
    assign lose      = capture && full && !pop;
    assign overwrite = lose && (mode_q == RING);

    assign unused_order_hi = ^trace.rvfi_order[63:OrderW];

    always_comb begin
        wrec          = '0;
        wrec.order    = ORDER_W'(trace.rvfi_order[OrderW-1:0]);
        wrec.pc       = trace.rvfi_pc_rdata;
        wrec.insn     = trace.rvfi_insn;
        wrec.rd_addr  = trace.rvfi_rd_addr;
        wrec.rd_wdata = trace.rvfi_rd_wdata;
        wrec.mem_addr = trace.rvfi_mem_addr;
        wrec.trap     = trace.rvfi_trap;
`ifdef IBEXC_TRACE_CAP_EN
        wrec.rd_wcap  = trace.rvfi_rd_wcap;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mode_q  <= STREAM;
            post_q  <= '0;
            drop_q  <= '0;
        end else begin
            if (state_q == IDLE) begin
                mode_q <= trace_mode_e'(mode_i);
            end
            if (clear_i) begin
                state_q <= enable_i ? ARMED : IDLE;
                post_q  <= '0;
                drop_q  <= '0;
            end else begin
                if (lose && drop_q != '1) begin
                    drop_q <= drop_q + DropCntW'(1);
                end
                case (state_q)
                    IDLE: begin
                        if (enable_i) state_q <= ARMED;
                    end
                    ARMED: begin
                        if (!enable_i) begin
                            state_q <= IDLE;
                        end else if (capture && trace.rvfi_trap && trig_on_trap_i) begin
                            post_q  <= post_cnt_i;
                            state_q <= (post_cnt_i == 8'd0) ? FROZEN : POST;
                        end
                    end
                    POST: begin
                        if (!enable_i) begin
                            state_q <= IDLE;
                        end else if (capture) begin
                            post_q <= post_q - 8'd1;
                            if (post_q == 8'd1) state_q <= FROZEN;
                        end
                    end
                    FROZEN: ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    ibexc_trace_ring #(
        .Depth (Depth)
    ) u_ring (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .push_i      (push),
        .pop_i       (pop),
        .overwrite_i (overwrite),
        .wdata_i     (wrec),
        .head_o      (trace.rec_data),
        .empty_o     (empty),
        .full_o      (full),
        .level_o     (level_o)
    );

    assign trace.rec_valid = !empty;
    assign drop_cnt_o      = drop_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_ibexc_rvfi_trace_buf.sv
// Self-checking bench for ibexc_rvfi_trace_buf against a queue-based reference model.
// Define IBEXC_TRACE_CAP_EN for both bench and RTL to exercise the rd_wcap field.
module tb_ibexc_rvfi_trace_buf;
    import ibexc_trace_pkg::*;

    localparam int DEPTH    = 16;
    localparam int DROP_W   = 4;
    localparam int LVL_W    = $clog2(DEPTH) + 1;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk_i          = 1'b0;
    logic              rst_ni         = 1'b0;
    logic              enable_i       = 1'b0;
    logic              clear_i        = 1'b0;
    logic              mode_i         = 1'b0;
    logic              trig_on_trap_i = 1'b0;
    logic [7:0]        post_cnt_i     = 8'd0;
    logic [LVL_W-1:0]  level_o;
    logic [DROP_W-1:0] drop_cnt_o;
    trace_state_e      state_o;

    ibexc_rvfi_trace_buf_if bus ();

    ibexc_rvfi_trace_buf #(
        .Depth    (DEPTH),
        .OrderW   (ORDER_W),
        .DropCntW (DROP_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .clear_i        (clear_i),
        .mode_i         (mode_i),
        .trig_on_trap_i (trig_on_trap_i),
        .post_cnt_i     (post_cnt_i),
        .trace          (bus),
        .level_o        (level_o),
        .drop_cnt_o     (drop_cnt_o),
        .state_o        (state_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: the buffer is a queue of records, oldest first.
    trace_rec_t   m_q[$];
    trace_rec_t   drained[$];
    int           m_drops = 0;
    int           m_post  = 0;
    bit           m_ring  = 1'b0;
    trace_state_e m_state = IDLE;

    function automatic trace_rec_t rand_rec(input int order, input bit trap);
        trace_rec_t r;
        r          = '0;
        r.order    = ORDER_W'(order);
        r.pc       = $urandom;
        r.insn     = $urandom;
        r.rd_addr  = 5'($urandom_range(31));
        r.rd_wdata = $urandom;
        r.mem_addr = $urandom;
        r.trap     = trap;
`ifdef IBEXC_TRACE_CAP_EN
        r.rd_wcap.valid  = 1'($urandom);
        r.rd_wcap.cursor = $urandom;
        r.rd_wcap.meta   = $urandom;
`endif
        return r;
    endfunction

    // Drive one clock of stimulus, then advance the model by the same clock.
    task automatic drive_cycle(input bit valid, input trace_rec_t r, input bit ready);
        bit capture;
        bus.rvfi_valid    = valid;
        bus.rvfi_order    = {32'($urandom), 16'($urandom), r.order};
        bus.rvfi_pc_rdata = r.pc;
        bus.rvfi_insn     = r.insn;
        bus.rvfi_rd_addr  = r.rd_addr;
        bus.rvfi_rd_wdata = r.rd_wdata;
        bus.rvfi_mem_addr = r.mem_addr;
        bus.rvfi_trap     = r.trap;
`ifdef IBEXC_TRACE_CAP_EN
        bus.rvfi_rd_wcap  = r.rd_wcap;
`endif
        bus.rec_ready     = ready;
        @(posedge clk_i);
        #1;
        bus.rvfi_valid = 1'b0;
        bus.rec_ready  = 1'b0;

        capture = valid && !clear_i && (m_state == ARMED || m_state == POST);
        if (clear_i) begin
            m_q.delete();
            m_drops = 0;
        end else begin
            if (ready && m_q.size() > 0) void'(m_q.pop_front());
            if (capture) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(r);
                end else begin
                    if (m_ring) begin
                        void'(m_q.pop_front());
                        m_q.push_back(r);
                    end
                    if (m_drops < DROP_MAX) m_drops++;
                end
            end
        end

        if (m_state == IDLE) m_ring = mode_i;
        if (clear_i) begin
            m_state = enable_i ? ARMED : IDLE;
        end else if (m_state == IDLE) begin
            if (enable_i) m_state = ARMED;
        end else if (m_state == ARMED || m_state == POST) begin
            if (!enable_i) begin
                m_state = IDLE;
            end else if (m_state == ARMED && capture && r.trap && trig_on_trap_i) begin
                m_post  = int'(post_cnt_i);
                m_state = (m_post == 0) ? FROZEN : POST;
            end else if (m_state == POST && capture) begin
                m_post--;
                if (m_post == 0) m_state = FROZEN;
            end
        end
    endtask

    task automatic setup(input bit ring, input bit trig, input int post);
        enable_i       = 1'b0;
        clear_i        = 1'b1;
        mode_i         = ring;
        trig_on_trap_i = trig;
        post_cnt_i     = 8'(post);
        drive_cycle(1'b0, '0, 1'b0);
        clear_i = 1'b0;
        drive_cycle(1'b0, '0, 1'b0);
        enable_i = 1'b1;
        drive_cycle(1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        drained.delete();
        for (int n = 0; n < DEPTH + 4 && bus.rec_valid; n++) begin
            drained.push_back(bus.rec_data);
            drive_cycle(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_reset();
        checks++; if (level_o !== '0) begin errors++; $display("[TB] FAIL reset_level got %0d expected 0", level_o); end
        checks++; if (drop_cnt_o !== '0) begin errors++; $display("[TB] FAIL reset_drop got %0d expected 0", drop_cnt_o); end
        checks++; if (state_o !== IDLE) begin errors++; $display("[TB] FAIL reset_state got %0d expected %0d", state_o, IDLE); end
        checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", bus.rec_valid); end
        checks++; if (bus.rec_data !== '0) begin errors++; $display("[TB] FAIL reset_data got %h expected 0", bus.rec_data); end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_stream();
        trace_rec_t exp[$];
        setup(1'b0, 1'b0, 0);
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, rand_rec(i, 1'b0), 1'b0);
        checks++; if (level_o !== LVL_W'(16)) begin errors++; $display("[TB] FAIL stream_level got %0d expected 16", level_o); end
        checks++; if (drop_cnt_o !== DROP_W'(4)) begin errors++; $display("[TB] FAIL stream_drop got %0d expected 4", drop_cnt_o); end
        exp = m_q;
        drain();
        checks++; if (drained.size() != 16) begin errors++; $display("[TB] FAIL stream_count got %0d expected 16", drained.size()); end
        for (int i = 0; i < exp.size() && i < drained.size(); i++) begin
            checks++;
            if (drained[i] !== exp[i] || drained[i].order !== ORDER_W'(i)) begin
                errors++; $display("[TB] FAIL stream_rec[%0d] got %h expected %h", i, drained[i], exp[i]);
            end
        end
    endtask

    task automatic test_ring();
        trace_rec_t exp[$];
        setup(1'b1, 1'b0, 0);
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, rand_rec(i, 1'b0), 1'b0);
        checks++; if (level_o !== LVL_W'(16)) begin errors++; $display("[TB] FAIL ring_level got %0d expected 16", level_o); end
        checks++; if (drop_cnt_o !== DROP_W'(4)) begin errors++; $display("[TB] FAIL ring_drop got %0d expected 4", drop_cnt_o); end
        exp = m_q;
        drain();
        checks++; if (drained.size() != 16) begin errors++; $display("[TB] FAIL ring_count got %0d expected 16", drained.size()); end
        for (int i = 0; i < exp.size() && i < drained.size(); i++) begin
            checks++;
            if (drained[i] !== exp[i] || drained[i].order !== ORDER_W'(i + 4)) begin
                errors++; $display("[TB] FAIL ring_rec[%0d] got %h expected %h", i, drained[i], exp[i]);
            end
        end
    endtask

    task automatic test_trigger();
        trace_rec_t exp[$];
        setup(1'b1, 1'b1, 3);
        for (int i = 0; i < 30; i++) drive_cycle(1'b1, rand_rec(i, i == 10), 1'b0);
        checks++; if (state_o !== FROZEN) begin errors++; $display("[TB] FAIL trig_state got %0d expected %0d", state_o, FROZEN); end
        checks++; if (level_o !== LVL_W'(14)) begin errors++; $display("[TB] FAIL trig_level got %0d expected 14", level_o); end
        exp = m_q;
        drain();
        checks++; if (drained.size() != 14) begin errors++; $display("[TB] FAIL trig_count got %0d expected 14", drained.size()); end
        for (int i = 0; i < exp.size() && i < drained.size(); i++) begin
            checks++;
            if (drained[i] !== exp[i] || drained[i].order !== ORDER_W'(i)) begin
                errors++; $display("[TB] FAIL trig_rec[%0d] got %h expected %h", i, drained[i], exp[i]);
            end
        end
    endtask

    task automatic test_full_push_pop();
        trace_rec_t exp[$];
        setup(1'b0, 1'b0, 0);
        for (int i = 0; i < 16; i++) drive_cycle(1'b1, rand_rec(i, 1'b0), 1'b0);
        checks++; if (bus.rec_data.order !== ORDER_W'(0)) begin errors++; $display("[TB] FAIL fpp_pop_order got %0d expected 0", bus.rec_data.order); end
        drive_cycle(1'b1, rand_rec(16, 1'b0), 1'b1);
        checks++; if (level_o !== LVL_W'(16)) begin errors++; $display("[TB] FAIL fpp_level got %0d expected 16", level_o); end
        checks++; if (drop_cnt_o !== DROP_W'(0)) begin errors++; $display("[TB] FAIL fpp_drop got %0d expected 0", drop_cnt_o); end
        exp = m_q;
        drain();
        checks++; if (drained.size() != 16) begin errors++; $display("[TB] FAIL fpp_count got %0d expected 16", drained.size()); end
        for (int i = 0; i < exp.size() && i < drained.size(); i++) begin
            checks++;
            if (drained[i] !== exp[i] || drained[i].order !== ORDER_W'(i + 1)) begin
                errors++; $display("[TB] FAIL fpp_rec[%0d] got %h expected %h", i, drained[i], exp[i]);
            end
        end
    endtask

    task automatic test_clear();
        setup(1'b0, 1'b0, 0);
        for (int i = 0; i < 18; i++) drive_cycle(1'b1, rand_rec(i, 1'b0), 1'b0);
        checks++; if (drop_cnt_o !== DROP_W'(2)) begin errors++; $display("[TB] FAIL clear_pre_drop got %0d expected 2", drop_cnt_o); end
        clear_i = 1'b1;
        drive_cycle(1'b1, rand_rec(99, 1'b0), 1'b0);
        clear_i = 1'b0;
        checks++; if (level_o !== '0) begin errors++; $display("[TB] FAIL clear_level got %0d expected 0", level_o); end
        checks++; if (drop_cnt_o !== '0) begin errors++; $display("[TB] FAIL clear_drop got %0d expected 0", drop_cnt_o); end
        checks++; if (state_o !== ARMED) begin errors++; $display("[TB] FAIL clear_state got %0d expected %0d", state_o, ARMED); end
        checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear_valid got %b expected 0", bus.rec_valid); end
        drive_cycle(1'b1, rand_rec(7, 1'b0), 1'b0);
        checks++; if (bus.rec_valid !== 1'b1) begin errors++; $display("[TB] FAIL clear_next_valid got %b expected 1", bus.rec_valid); end
        checks++;
        if (bus.rec_data !== m_q[0] || bus.rec_data.order !== ORDER_W'(7)) begin
            errors++; $display("[TB] FAIL clear_next_rec got %h expected %h", bus.rec_data, m_q[0]);
        end
    endtask

    task automatic test_saturate();
        setup(1'b0, 1'b0, 0);
        for (int i = 0; i < 36; i++) drive_cycle(1'b1, rand_rec(i, 1'b0), 1'b0);
        checks++; if (drop_cnt_o !== DROP_W'(DROP_MAX)) begin errors++; $display("[TB] FAIL sat_drop got %0d expected %0d", drop_cnt_o, DROP_MAX); end
        checks++; if (level_o !== LVL_W'(16)) begin errors++; $display("[TB] FAIL sat_level got %0d expected 16", level_o); end
    endtask

    task automatic test_random_traffic();
        bit valid;
        bit ready;
        setup(1'($urandom), 1'b0, 0);
        for (int i = 0; i < 300; i++) begin
            valid    = ($urandom_range(99) < 70);
            ready    = ($urandom_range(99) < 40);
            enable_i = ($urandom_range(99) < 90);
            checks++;
            if (bus.rec_valid !== (m_q.size() != 0)) begin
                errors++; $display("[TB] FAIL rand_valid[%0d] got %b expected %b", i, bus.rec_valid, m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                checks++;
                if (bus.rec_data !== m_q[0]) begin
                    errors++; $display("[TB] FAIL rand_head[%0d] got %h expected %h", i, bus.rec_data, m_q[0]);
                end
            end
            drive_cycle(valid, rand_rec(i, 1'($urandom)), ready);
            checks++;
            if (level_o !== LVL_W'(m_q.size()) || drop_cnt_o !== DROP_W'(m_drops) || state_o !== m_state) begin
                errors++;
                $display("[TB] FAIL rand_status[%0d] got level %0d drop %0d state %0d expected level %0d drop %0d state %0d",
                         i, level_o, drop_cnt_o, state_o, m_q.size(), m_drops, m_state);
            end
        end
        enable_i = 1'b1;
    endtask

    task automatic test_reset_mid_post();
        setup(1'b1, 1'b1, 5);
        for (int i = 0; i < 18; i++) drive_cycle(1'b1, rand_rec(i, i == 14), 1'b0);
        checks++; if (state_o !== POST) begin errors++; $display("[TB] FAIL rpost_state got %0d expected %0d", state_o, POST); end
        checks++; if (drop_cnt_o !== DROP_W'(2)) begin errors++; $display("[TB] FAIL rpost_drop got %0d expected 2", drop_cnt_o); end
`ifdef IBEXC_TRACE_CAP_EN
        checks++;
        if (bus.rec_data.rd_wcap !== m_q[0].rd_wcap) begin
            errors++; $display("[TB] FAIL rpost_wcap got %h expected %h", bus.rec_data.rd_wcap, m_q[0].rd_wcap);
        end
`endif
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (level_o !== '0) begin errors++; $display("[TB] FAIL rpost_level got %0d expected 0", level_o); end
        checks++; if (drop_cnt_o !== '0) begin errors++; $display("[TB] FAIL rpost_drop0 got %0d expected 0", drop_cnt_o); end
        checks++; if (state_o !== IDLE) begin errors++; $display("[TB] FAIL rpost_idle got %0d expected %0d", state_o, IDLE); end
        checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("[TB] FAIL rpost_valid got %b expected 0", bus.rec_valid); end
        checks++; if (bus.rec_data !== '0) begin errors++; $display("[TB] FAIL rpost_data got %h expected 0", bus.rec_data); end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        m_q.delete();
        m_drops = 0;
        m_state = IDLE;
        m_ring  = 1'b0;
    endtask

    initial begin
        bus.rvfi_valid    = 1'b0;
        bus.rvfi_order    = '0;
        bus.rvfi_pc_rdata = '0;
        bus.rvfi_insn     = '0;
        bus.rvfi_rd_addr  = '0;
        bus.rvfi_rd_wdata = '0;
        bus.rvfi_mem_addr = '0;
        bus.rvfi_trap     = 1'b0;
`ifdef IBEXC_TRACE_CAP_EN
        bus.rvfi_rd_wcap  = '0;
`endif
        bus.rec_ready     = 1'b0;
        @(posedge clk_i);
        #1;
        test_reset();
        test_stream();
        test_ring();
        test_trigger();
        test_full_push_pop();
        test_clear();
        test_saturate();
        test_random_traffic();
        test_reset_mid_post();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
